idx_ram_mc: RTL

Multi-channel index RAM: next generation of the gather-engine index store. One MMIO write port fills a 2^ADDR_WIDTH × DATA_WIDTH array. NUM_CH independent gather read channels each use a valid/ready request/response handshake, a registered 1-cycle read and write-first forwarding. A hardware clear sequencer zeroes the array without MMIO traffic. The block sits between the MMIO register file (write/clear) and the gather address generators (read channels).

---
 rtl/idx_ram_mc.sv | 134 +++++++++++++
 1 files changed

// File: rtl/idx_ram_mc.sv
// idx_ram_mc: multi-channel gather index store.
// One MMIO write port fills a 2^ADDR_WIDTH x DATA_WIDTH array; NUM_CH independent
// read channels each have a valid/ready request/response handshake with a
// registered one-cycle read and write-first forwarding. A hardware sequencer
// zero-fills the array one word per cycle after a clr_start pulse.
module idx_ram_mc #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wen,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic                             clr_start,
    output logic                             clr_busy,
    input  logic [NUM_CH-1:0]                rd_req_valid,
    output logic [NUM_CH-1:0]                rd_req_ready,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]     rd_req_addr,
    output logic [NUM_CH-1:0]                rd_rsp_valid,
    input  logic [NUM_CH-1:0]                rd_rsp_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0]     rd_rsp_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Pointer is one bit wider than the address so the terminal compare never wraps.
    localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    clr_state_t              state_q;
    logic [ADDR_WIDTH:0]     ptr_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    clr_busy_s;
    logic                    clr_accept_s;
    logic                    wr_en_s;

    // Decode clear status and whether the MMIO write is allowed this cycle (clear wins).
    always_comb begin
        clr_busy_s   = (state_q == ST_CLEAR);
        clr_accept_s = (state_q == ST_IDLE) && clr_start;
        wr_en_s      = wen && !clr_busy_s && !clr_accept_s;
    end

    assign clr_busy = clr_busy_s;

    // Clear sequencer: walks the pointer across every word once per clr_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= {(ADDR_WIDTH + 1){1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr_start) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= {(ADDR_WIDTH + 1){1'b0}};
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (ptr_q == LAST_PTR) begin
                        state_q <= ST_IDLE;
                    end else begin
                        ptr_q <= ptr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ptr_q   <= {(ADDR_WIDTH + 1){1'b0}};
                end
            endcase
        end
    end

    // Array update: zero-fill while clearing, else MMIO write; nothing lands during reset
    // so a reset mid-clear leaves the not-yet-reached words intact.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_busy_s) begin
                mem_q[ptr_q[ADDR_WIDTH-1:0]] <= {DATA_WIDTH{1'b0}};
            end else if (wr_en_s) begin
                mem_q[waddr] <= wdata;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ADDR_WIDTH-1:0] addr_s;
        logic                  ready_s;
        logic                  accept_s;
        logic [DATA_WIDTH-1:0] rsp_data_d;
        logic                  rsp_valid_q;
        logic [DATA_WIDTH-1:0] rsp_data_q;

        // Request handshake and write-first selection of the word to capture.
        always_comb begin
            addr_s   = rd_req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
            ready_s  = !clr_busy_s && (!rsp_valid_q || rd_rsp_ready[c]);
            accept_s = rd_req_valid[c] && ready_s;
            if (wr_en_s && (waddr == addr_s)) begin
                rsp_data_d = wdata;
            end else begin
                rsp_data_d = mem_q[addr_s];
            end
        end

        // Response register: load on accept, drop valid on drain, hold data otherwise.
        always_ff @(posedge clk) begin
            if (rst) begin
                rsp_valid_q <= 1'b0;
                rsp_data_q  <= {DATA_WIDTH{1'b0}};
            end else if (accept_s) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rsp_data_d;
            end else if (rsp_valid_q && rd_rsp_ready[c]) begin
                rsp_valid_q <= 1'b0;
            end else begin
                rsp_valid_q <= rsp_valid_q;
            end
        end

        assign rd_req_ready[c]                          = ready_s;
        assign rd_rsp_valid[c]                          = rsp_valid_q;
        assign rd_rsp_data[c*DATA_WIDTH +: DATA_WIDTH]  = rsp_data_q;
    end

endmodule
